// File: rtl/gpio_pkg.sv
// Shared types and constants for the GPIO interrupt controller.
// The debounce option is enabled by defining GPIO_IRQ_DEBOUNCE_EN.
package gpio_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  typedef enum logic {
    IRQ_IDLE    = 1'b0,
    IRQ_PRESENT = 1'b1
  } irq_state_e;

  // Cycles after reset release during which edge detection is masked.
  localparam int WARMUP_CYCLES = 3;

`ifdef GPIO_IRQ_DEBOUNCE_EN
  localparam bit DBNC_EN = 1'b1;
`else
  localparam bit DBNC_EN = 1'b0;
`endif

endpackage

// File: rtl/gpio_in_filter.sv
// Per-pin 2-flop synchroniser with an optional debounce filter.
// Debounce is built only when GPIO_IRQ_DEBOUNCE_EN is defined.
module gpio_in_filter
`ifdef GPIO_IRQ_DEBOUNCE_EN
  #(parameter int DBNC_CYCLES = 4)
`endif
  (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_in,
  output logic level
);

  logic sync1_reg;
  logic sync2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= pin_in;
      sync2_reg <= sync1_reg;
    end
  end

`ifdef GPIO_IRQ_DEBOUNCE_EN
  localparam int CNT_W = (DBNC_CYCLES > 2) ? $clog2(DBNC_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_reg;
  logic             filt_reg;

  // Counts consecutive samples that disagree with the filtered level; the
  // level flips on the DBNC_CYCLES-th such sample, any agreement restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      filt_reg <= 1'b0;
    end else if (sync2_reg == filt_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_W'(DBNC_CYCLES - 1)) begin
      cnt_reg  <= '0;
      filt_reg <= sync2_reg;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign level = filt_reg;
`else
  assign level = sync2_reg;
`endif

endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO interrupt controller: edge detect, pending latch, lowest-index arbiter.
// Optional per-pin debounce via GPIO_IRQ_DEBOUNCE_EN.
module gpio_irq_ctrl
  import gpio_pkg::*;
#(
  parameter int N_PINS      = 8,
  parameter int DBNC_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_PINS-1:0]         gpio_in,
  input  logic [2*N_PINS-1:0]       cfg_mode,
  input  logic [N_PINS-1:0]         cfg_mask,
  output logic [N_PINS-1:0]         pending,
  output logic                      irq,
  output logic                      irq_valid,
  output logic [$clog2(N_PINS)-1:0] irq_id,
  input  logic                      irq_ready
);

  localparam int ID_W     = $clog2(N_PINS);
  // The debounce stage starts at 0 too, so pins high at reset need the
  // warm-up stretched by the filter delay to avoid a false rising edge.
  localparam int WARM_LEN = WARMUP_CYCLES + (DBNC_EN ? DBNC_CYCLES : 0);
  localparam int WARM_W   = $clog2(WARM_LEN + 1);

  logic [N_PINS-1:0] level;
  logic [N_PINS-1:0] prev_reg;
  logic [N_PINS-1:0] edge_hit;
  logic [N_PINS-1:0] pending_reg, pending_next;
  logic [N_PINS-1:0] clr_vec;
  logic [N_PINS-1:0] eligible;
  logic [WARM_W-1:0] warm_cnt_reg;
  logic              warm_done;
  logic              irq_reg;
  irq_state_e        state_reg, state_next;
  logic [ID_W-1:0]   irq_id_reg, irq_id_next;
  logic [ID_W-1:0]   lowest;

  genvar gi;
  generate
    for (gi = 0; gi < N_PINS; gi++) begin : g_pin
      edge_mode_e mode;
      logic       rise;
      logic       fall;

`ifdef GPIO_IRQ_DEBOUNCE_EN
      gpio_in_filter #(.DBNC_CYCLES(DBNC_CYCLES)) u_filter (
`else
      gpio_in_filter u_filter (
`endif
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_in (gpio_in[gi]),
        .level  (level[gi])
      );

      assign mode = edge_mode_e'(cfg_mode[2*gi +: 2]);
      assign rise = level[gi] & ~prev_reg[gi];
      assign fall = ~level[gi] & prev_reg[gi];
      assign edge_hit[gi] = (rise & (mode == EDGE_RISE || mode == EDGE_BOTH)) |
                            (fall & (mode == EDGE_FALL || mode == EDGE_BOTH));
    end
  endgenerate

  assign warm_done = (warm_cnt_reg == WARM_W'(WARM_LEN));
  assign eligible  = pending_reg & cfg_mask;
  assign clr_vec   = (state_reg == IRQ_PRESENT && irq_ready)
                     ? (N_PINS'(1) << irq_id_reg) : '0;
  // A fresh edge in the clear cycle overrides the clear.
  assign pending_next = (pending_reg & ~clr_vec) | (warm_done ? edge_hit : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_reg     <= '0;
      pending_reg  <= '0;
      warm_cnt_reg <= '0;
      irq_reg      <= 1'b0;
    end else begin
      prev_reg    <= level;
      pending_reg <= pending_next;
      irq_reg     <= |eligible;
      if (!warm_done) warm_cnt_reg <= warm_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    lowest = '0;
    for (int i = N_PINS - 1; i >= 0; i--) begin
      if (eligible[i]) lowest = ID_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IRQ_IDLE;
      irq_id_reg <= '0;
    end else begin
      state_reg  <= state_next;
      irq_id_reg <= irq_id_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    irq_id_next = irq_id_reg;
    case (state_reg)
      IRQ_IDLE: begin
        if (|eligible) begin
          state_next  = IRQ_PRESENT;
          irq_id_next = lowest;
        end
      end
      IRQ_PRESENT: begin
        if (irq_ready) state_next = IRQ_IDLE;
      end
      default: state_next = IRQ_IDLE;
    endcase
  end

  assign pending   = pending_reg;
  assign irq       = irq_reg;
  assign irq_valid = (state_reg == IRQ_PRESENT);
  assign irq_id    = irq_id_reg;

endmodule
